// File: rtl/hs_channel_pkg.sv
// hs_channel_pkg: shared types and defaults for the handshake channel arbiter
// and its round-robin picker.
package hs_channel_pkg;

  localparam int DEF_N_REQ       = 4;
  localparam int DEF_TIMEOUT_CYC = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    COMMIT  = 2'd2,
    RELEASE = 2'd3
  } state_t;

  // Width of an index into n requesters, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker. Returns the first set bit of req
// at or after ptr, wrapping modulo N. valid is low when req is all zero.
// ptr is expected to be below N.
module rr_pick
  import hs_channel_pkg::*;
#(
  parameter int N = DEF_N_REQ,
  parameter int W = idx_width(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         valid,
  output logic [W-1:0] idx
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [W:0]     sum;
  int             first;

  // Rotate the request vector so ptr lands at bit 0, find the lowest set bit,
  // then map that offset back to an absolute index modulo N.
  always_comb begin
    dbl   = {req, req};
    rot   = N'(dbl >> ptr);
    valid = |rot;
    first = 0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) first = k;
    end
    sum = (W+1)'(ptr) + (W+1)'(first);
    if (sum >= (W+1)'(N)) sum = sum - (W+1)'(N);
    idx = sum[W-1:0];
  end

endmodule

// File: rtl/hs_channel_arbiter.sv
// hs_channel_arbiter: shares one downstream req/ack/commit channel among N_REQ
// requesters with round-robin arbitration, one transaction at a time.
// Transaction flow: IDLE -> REQ -> COMMIT -> RELEASE -> IDLE.
// Optional feature macro HS_CHANNEL_ARBITER_TIMEOUT_EN: abandons a REQ that
// sees no dn_ack within TIMEOUT_CYC cycles and raises the sticky err flag.
// rst asserts asynchronously; its release is expected to be synchronous to clk.
module hs_channel_arbiter
  import hs_channel_pkg::*;
#(
  parameter int N_REQ       = DEF_N_REQ,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              up_req,
  output logic [N_REQ-1:0]              up_ack,
  input  logic [N_REQ-1:0]              up_commit,
  output logic                          dn_req,
  input  logic                          dn_ack,
  output logic                          dn_commit,
  output logic [idx_width(N_REQ)-1:0]   gnt_idx,
  output logic                          busy,
  output logic                          err
);

  localparam int IW = idx_width(N_REQ);

  state_t           state;
  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    next_ptr;
  logic [IW-1:0]    pick_idx;
  logic             pick_valid;
  logic [N_REQ-1:0] gnt_onehot;

  rr_pick #(
    .N (N_REQ),
    .W (IW)
  ) u_pick (
    .req   (up_req),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign next_ptr   = (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  assign gnt_onehot = N_REQ'(1) << gnt_idx;

`ifdef HS_CHANNEL_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] tmo_cnt;
  logic          tmo_hit;

  assign tmo_hit = (tmo_cnt == CW'(TIMEOUT_CYC - 1));
`else
  assign err = 1'b0;
`endif

  // Transaction FSM; every output is a register updated here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      gnt_idx   <= '0;
      up_ack    <= '0;
      dn_req    <= 1'b0;
      dn_commit <= 1'b0;
      busy      <= 1'b0;
`ifdef HS_CHANNEL_ARBITER_TIMEOUT_EN
      tmo_cnt   <= '0;
      err       <= 1'b0;
`endif
    end else begin
      dn_commit <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            gnt_idx <= pick_idx;
            dn_req  <= 1'b1;
            busy    <= 1'b1;
            state   <= REQ;
`ifdef HS_CHANNEL_ARBITER_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
          end
        end
        REQ: begin
          if (dn_ack) begin
            up_ack <= gnt_onehot;
            state  <= COMMIT;
          end
`ifdef HS_CHANNEL_ARBITER_TIMEOUT_EN
          else if (tmo_hit) begin
            dn_req <= 1'b0;
            busy   <= 1'b0;
            err    <= 1'b1;
            rr_ptr <= next_ptr;
            state  <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        COMMIT: begin
          if (up_commit[gnt_idx]) begin
            dn_commit <= 1'b1;
            dn_req    <= 1'b0;
            state     <= RELEASE;
          end
        end
        RELEASE: begin
          if (!up_req[gnt_idx] && !dn_ack) begin
            up_ack <= '0;
            busy   <= 1'b0;
            rr_ptr <= next_ptr;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hs_channel_arbiter.sv
// tb_hs_channel_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level round-robin model.
module tb_hs_channel_arbiter;

  localparam int N   = 4;
  localparam int TMO = 16;

  logic         clk;
  logic         rst;
  logic [N-1:0] up_req;
  logic [N-1:0] up_ack;
  logic [N-1:0] up_commit;
  logic         dn_req;
  logic         dn_ack;
  logic         dn_commit;
  logic [1:0]   gnt_idx;
  logic         busy;
  logic         err;

  int   checks = 0;
  int   errors = 0;
  int   ack_mode = 0;
  logic ack_force = 1'b0;
  int   phase [N];

  hs_channel_arbiter #(
    .N_REQ       (N),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .up_req    (up_req),
    .up_ack    (up_ack),
    .up_commit (up_commit),
    .dn_req    (dn_req),
    .dn_ack    (dn_ack),
    .dn_commit (dn_commit),
    .gnt_idx   (gnt_idx),
    .busy      (busy),
    .err       (err)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Downstream responder: echoes dn_req, echoes with random stalls, or forces a level.
  always @(negedge clk) begin
    case (ack_mode)
      0:       dn_ack = dn_req;
      1:       dn_ack = dn_req && ($urandom_range(0, 2) != 0);
      default: dn_ack = ack_force;
    endcase
  end

  // Hard stop in case something hangs.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Round-robin rule: first requester at or after ptr, wrapping.
  function automatic int rr_expect(input logic [N-1:0] req, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (req[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic do_reset(input logic [N-1:0] req_hold);
    rst       = 1'b1;
    up_req    = req_hold;
    up_commit = '0;
    for (int i = 0; i < N; i++) phase[i] = req_hold[i] ? 1 : 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Requester agents: request, commit once acked, drop request, re-request.
  task automatic agent_step(input bit rnd);
    for (int i = 0; i < N; i++) begin
      case (phase[i])
        0: begin
          up_commit[i] = 1'b0;
          if (!rnd || $urandom_range(0, 3) == 0) begin
            up_req[i] = 1'b1;
            phase[i]  = 1;
          end
        end
        1: begin
          if (up_ack[i]) begin
            if (!rnd || $urandom_range(0, 1) == 1) begin
              up_commit[i] = 1'b1;
              phase[i]     = 2;
            end else begin
              up_commit[i] = 1'b0;
            end
          end else begin
            up_commit[i] = rnd && ($urandom_range(0, 7) == 0);
          end
        end
        default: begin
          up_commit[i] = 1'b0;
          up_req[i]    = 1'b0;
          if (!up_ack[i]) phase[i] = 0;
        end
      endcase
    end
  endtask

  task automatic test_reset();
    do_reset('0);
    checks++; if (dn_req !== 1'b0)    begin errors++; $display("[TB] FAIL reset_dn_req: got %b expected 0", dn_req); end
    checks++; if (up_ack !== 4'b0)    begin errors++; $display("[TB] FAIL reset_up_ack: got %b expected 0000", up_ack); end
    checks++; if (dn_commit !== 1'b0) begin errors++; $display("[TB] FAIL reset_dn_commit: got %b expected 0", dn_commit); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (gnt_idx !== 2'd0)   begin errors++; $display("[TB] FAIL reset_gnt_idx: got %0d expected 0", gnt_idx); end
    checks++; if (err !== 1'b0)       begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
  endtask

  task automatic test_single();
    ack_mode = 0;
    up_req   = 4'b0100;
    @(negedge clk);
    checks++; if (gnt_idx !== 2'd2) begin errors++; $display("[TB] FAIL single_gnt: got %0d expected 2", gnt_idx); end
    checks++; if (dn_req !== 1'b1)  begin errors++; $display("[TB] FAIL single_dn_req: got %b expected 1", dn_req); end
    checks++; if (busy !== 1'b1)    begin errors++; $display("[TB] FAIL single_busy: got %b expected 1", busy); end
    checks++; if (up_ack !== 4'b0)  begin errors++; $display("[TB] FAIL single_early_ack: got %b expected 0000", up_ack); end
    @(negedge clk);
    checks++; if (up_ack !== 4'b0100) begin errors++; $display("[TB] FAIL single_up_ack: got %b expected 0100", up_ack); end
    checks++; if (dn_commit !== 1'b0) begin errors++; $display("[TB] FAIL single_no_commit: got %b expected 0", dn_commit); end
    up_commit = 4'b0100;
    @(negedge clk);
    checks++; if (dn_commit !== 1'b1) begin errors++; $display("[TB] FAIL single_commit: got %b expected 1", dn_commit); end
    checks++; if (dn_req !== 1'b0)    begin errors++; $display("[TB] FAIL single_release_req: got %b expected 0", dn_req); end
    up_commit = 4'b0000;
    @(negedge clk);
    checks++; if (dn_commit !== 1'b0) begin errors++; $display("[TB] FAIL single_pulse_len: got %b expected 0", dn_commit); end
    checks++; if (up_ack !== 4'b0100) begin errors++; $display("[TB] FAIL single_ack_hold: got %b expected 0100", up_ack); end
    checks++; if (busy !== 1'b1)      begin errors++; $display("[TB] FAIL single_busy_hold: got %b expected 1", busy); end
    up_req = 4'b0000;
    @(negedge clk);
    checks++; if (busy !== 1'b0)   begin errors++; $display("[TB] FAIL single_idle: got %b expected 0", busy); end
    checks++; if (up_ack !== 4'b0) begin errors++; $display("[TB] FAIL single_ack_clear: got %b expected 0000", up_ack); end
  endtask

  task automatic test_reset_mid();
    ack_mode = 0;
    up_req   = 4'b0100;
    @(negedge clk);
    checks++; if (gnt_idx !== 2'd2) begin errors++; $display("[TB] FAIL rmid_gnt: got %0d expected 2", gnt_idx); end
    @(negedge clk);
    checks++; if (up_ack !== 4'b0100) begin errors++; $display("[TB] FAIL rmid_in_commit: got %b expected 0100", up_ack); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (dn_req !== 1'b0) begin errors++; $display("[TB] FAIL rmid_async_dn_req: got %b expected 0", dn_req); end
    checks++; if (up_ack !== 4'b0) begin errors++; $display("[TB] FAIL rmid_async_up_ack: got %b expected 0000", up_ack); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("[TB] FAIL rmid_async_busy: got %b expected 0", busy); end
    @(negedge clk);
    rst    = 1'b0;
    up_req = 4'b1001;
    @(negedge clk);
    checks++; if (gnt_idx !== 2'd0) begin errors++; $display("[TB] FAIL rmid_ptr_reset: got %0d expected 0", gnt_idx); end
    checks++; if (dn_req !== 1'b1)  begin errors++; $display("[TB] FAIL rmid_regrant: got %b expected 1", dn_req); end
  endtask

  task automatic test_commit_other();
    do_reset('0);
    ack_mode = 0;
    up_req   = 4'b0010;
    @(negedge clk);
    checks++; if (gnt_idx !== 2'd1) begin errors++; $display("[TB] FAIL cother_gnt: got %0d expected 1", gnt_idx); end
    @(negedge clk);
    checks++; if (up_ack !== 4'b0010) begin errors++; $display("[TB] FAIL cother_ack: got %b expected 0010", up_ack); end
    up_commit = 4'b1000;
    @(negedge clk);
    checks++; if (dn_commit !== 1'b0) begin errors++; $display("[TB] FAIL cother_ignore1: got %b expected 0", dn_commit); end
    checks++; if (dn_req !== 1'b1)    begin errors++; $display("[TB] FAIL cother_req_hold: got %b expected 1", dn_req); end
    @(negedge clk);
    checks++; if (dn_commit !== 1'b0) begin errors++; $display("[TB] FAIL cother_ignore2: got %b expected 0", dn_commit); end
    checks++; if (up_ack !== 4'b0010) begin errors++; $display("[TB] FAIL cother_ack_hold: got %b expected 0010", up_ack); end
    up_commit = 4'b0010;
    @(negedge clk);
    checks++; if (dn_commit !== 1'b1) begin errors++; $display("[TB] FAIL cother_commit: got %b expected 1", dn_commit); end
    up_commit = 4'b0000;
    up_req    = 4'b0000;
    @(negedge clk);
    checks++; if (dn_commit !== 1'b0) begin errors++; $display("[TB] FAIL cother_pulse_len: got %b expected 0", dn_commit); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("[TB] FAIL cother_idle: got %b expected 0", busy); end
  endtask

  task automatic test_fairness();
    logic [1:0] exp_order [5];
    int         n;
    logic       prev_b;
    exp_order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    ack_mode  = 0;
    do_reset(4'b1111);
    n      = 0;
    prev_b = 1'b0;
    for (int cyc = 0; cyc < 200 && n < 5; cyc++) begin
      @(negedge clk);
      checks++; if (!$onehot0(up_ack)) begin errors++; $display("[TB] FAIL fair_onehot: got %b expected one-hot or zero", up_ack); end
      if (busy && !prev_b) begin
        checks++;
        if (gnt_idx !== exp_order[n]) begin errors++; $display("[TB] FAIL fair_order[%0d]: got %0d expected %0d", n, gnt_idx, exp_order[n]); end
        n++;
      end
      prev_b = busy;
      agent_step(1'b0);
    end
    checks++; if (n != 5) begin errors++; $display("[TB] FAIL fair_budget: got %0d grants expected 5", n); end
  endtask

  task automatic test_random();
    int           m_ptr, m_gnt, grants, exp_g;
    bit           m_busy, m_committed;
    logic         exp_dc, exp_busy;
    logic [N-1:0] prev_req, prev_commit, prev_ua, exp_ack;
    do_reset('0);
    ack_mode    = 1;
    m_ptr       = 0;
    m_gnt       = 0;
    grants      = 0;
    m_busy      = 0;
    m_committed = 0;
    prev_req    = '0;
    prev_commit = '0;
    prev_ua     = '0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      checks++; if (!$onehot0(up_ack)) begin errors++; $display("[TB] FAIL rand_onehot: got %b expected one-hot or zero", up_ack); end
      exp_dc = m_busy && prev_ua[m_gnt] && !m_committed && prev_commit[m_gnt];
      checks++; if (dn_commit !== exp_dc) begin errors++; $display("[TB] FAIL rand_dn_commit: got %b expected %b (cycle %0d)", dn_commit, exp_dc, cyc); end
      if (exp_dc) m_committed = 1;
      if (!m_busy) begin
        exp_busy = (prev_req != '0);
        checks++; if (busy !== exp_busy) begin errors++; $display("[TB] FAIL rand_grant_start: got busy %b expected %b (cycle %0d)", busy, exp_busy, cyc); end
        if (exp_busy) begin
          exp_g = rr_expect(prev_req, m_ptr);
          checks++; if (gnt_idx !== 2'(exp_g)) begin errors++; $display("[TB] FAIL rand_gnt: got %0d expected %0d (cycle %0d)", gnt_idx, exp_g, cyc); end
          m_gnt       = exp_g;
          m_busy      = 1;
          m_committed = 0;
          grants++;
        end
      end else if (!busy) begin
        checks++; if (!m_committed) begin errors++; $display("[TB] FAIL rand_release: got idle expected commit first (cycle %0d)", cyc); end
        m_ptr  = (m_gnt + 1) % N;
        m_busy = 0;
      end else begin
        exp_ack = 4'b0001 << m_gnt;
        checks++;
        if (up_ack !== '0 && up_ack !== exp_ack) begin errors++; $display("[TB] FAIL rand_ack_target: got %b expected 0000 or %b", up_ack, exp_ack); end
      end
      agent_step(1'b1);
      prev_req    = up_req;
      prev_commit = up_commit;
      prev_ua     = up_ack;
    end
    checks++; if (grants < 10) begin errors++; $display("[TB] FAIL rand_progress: got %0d grants expected at least 10", grants); end
  endtask

`ifdef HS_CHANNEL_ARBITER_TIMEOUT_EN
  task automatic test_timeout();
    do_reset('0);
    ack_mode  = 2;
    ack_force = 1'b0;
    up_req    = 4'b0110;
    for (int k = 0; k < TMO; k++) begin
      @(negedge clk);
      checks++; if (dn_req !== 1'b1) begin errors++; $display("[TB] FAIL tmo_req_high[%0d]: got %b expected 1", k, dn_req); end
      checks++; if (up_ack !== 4'b0) begin errors++; $display("[TB] FAIL tmo_no_ack[%0d]: got %b expected 0000", k, up_ack); end
    end
    @(negedge clk);
    checks++; if (dn_req !== 1'b0) begin errors++; $display("[TB] FAIL tmo_drop: got %b expected 0", dn_req); end
    checks++; if (err !== 1'b1)    begin errors++; $display("[TB] FAIL tmo_err: got %b expected 1", err); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("[TB] FAIL tmo_idle: got %b expected 0", busy); end
    @(negedge clk);
    checks++; if (gnt_idx !== 2'd2) begin errors++; $display("[TB] FAIL tmo_next_gnt: got %0d expected 2", gnt_idx); end
    checks++; if (dn_req !== 1'b1)  begin errors++; $display("[TB] FAIL tmo_next_req: got %b expected 1", dn_req); end
    checks++; if (err !== 1'b1)     begin errors++; $display("[TB] FAIL tmo_err_sticky: got %b expected 1", err); end
    do_reset('0);
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL tmo_err_clear: got %b expected 0", err); end
    ack_mode = 0;
  endtask
`else
  task automatic test_no_timeout();
    int bad;
    do_reset('0);
    ack_mode  = 2;
    ack_force = 1'b0;
    up_req    = 4'b0001;
    @(negedge clk);
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (dn_req !== 1'b1 || busy !== 1'b1 || err !== 1'b0 || up_ack !== 4'b0) bad++;
    end
    checks++; if (bad != 0)       begin errors++; $display("[TB] FAIL stall_hold: got %0d bad cycles expected 0", bad); end
    checks++; if (dn_req !== 1'b1) begin errors++; $display("[TB] FAIL stall_dn_req: got %b expected 1", dn_req); end
    checks++; if (err !== 1'b0)    begin errors++; $display("[TB] FAIL stall_err: got %b expected 0", err); end
    do_reset('0);
    ack_mode = 0;
  endtask
`endif

  // Scenario sequence and summary.
  initial begin
    rst       = 1'b1;
    up_req    = '0;
    up_commit = '0;
    $display("[TB] starting hs_channel_arbiter bench");
    test_reset();
    test_single();
    test_reset_mid();
    test_commit_other();
    test_fairness();
    test_random();
`ifdef HS_CHANNEL_ARBITER_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
